remora_link_supervisor: RTL

Supervises the SPI command link between the host and the motion datapath (stepgens, PWMs, digital outputs). It sits between the SPI slave's raw receive fields and the generator instances. A received frame is applied atomically only after header validation. A communication watchdog forces every actuator command to a safe zero state when frames stop arriving. Motion resumes only after a frame arrives with all joints disabled.

---
 rtl/remora_link_supervisor.sv | 101 ++++++++++
 1 files changed

// File: rtl/remora_link_supervisor.sv
// remora_link_supervisor: validates SPI frames, applies them atomically and forces safe outputs on link loss
module remora_link_supervisor #(
  parameter int NJOINTS = 3,
  parameter int NVOUT = 5,
  parameter int NDOUT = 4,
  parameter int TIMEOUT = 4800000,
  parameter int SETTLE = 2
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic                   SPI_SSEL,
  input  logic [31:0]            header_rx,
  input  logic [32*NJOINTS-1:0]  jointFreqCmd_raw,
  input  logic [16*NVOUT-1:0]    setPoint_raw,
  input  logic [NJOINTS-1:0]     jointEnable_raw,
  input  logic [NDOUT-1:0]       dout_raw,
  output logic [32*NJOINTS-1:0]  jointFreqCmd,
  output logic [16*NVOUT-1:0]    setPoint,
  output logic [NJOINTS-1:0]     jointEnable,
  output logic [NDOUT-1:0]       DOUT,
  output logic                   frame_strobe,
  output logic                   link_ok,
  output logic                   fault,
  output logic [15:0]            frame_count,
  output logic [7:0]             bad_count
);
  localparam logic [31:0] MAGIC = 32'h74697277;
  localparam int SW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {F_IDLE, F_SETTLE, F_CHECK} fstate_t;
  typedef enum logic [1:0] {SAFE, RUN, FAULT} lstate_t;
  fstate_t fstate, fnext;
  lstate_t lstate, lnext;
  logic ssel_s1, ssel_s2, ssel_d;
  logic [SW-1:0] settle_cnt, settle_next;
  logic [31:0] wd;
  logic eof, valid, arming, latch, reject, expire;
  assign eof = ssel_s2 & ~ssel_d;
  assign valid = header_rx == MAGIC;
  assign arming = valid && jointEnable_raw == '0;
  assign latch = fstate == F_CHECK && (lstate == RUN ? valid : arming);
  assign reject = fstate == F_CHECK && !latch;
  // a latch in the expiry cycle takes priority and keeps the link running
  assign expire = lstate == RUN && !latch && wd == 32'(TIMEOUT - 1);
  assign link_ok = lstate == RUN;
  always_comb begin
    fnext = fstate;
    settle_next = settle_cnt;
    case (fstate)
      F_IDLE: if (eof) begin
        fnext = SETTLE == 1 ? F_CHECK : F_SETTLE;
        settle_next = SW'(SETTLE);
      end
      F_SETTLE: begin
        settle_next = eof ? SW'(SETTLE) : settle_cnt - SW'(1);
        fnext = settle_next == SW'(1) ? F_CHECK : F_SETTLE;
      end
      default: fnext = F_IDLE;
    endcase
  end
  always_comb lnext = latch ? RUN : expire ? FAULT : lstate;
  always_ff @(posedge sysclk) begin
    if (rst) begin
      {ssel_s1, ssel_s2, ssel_d} <= '0;
      fstate <= F_IDLE;
      lstate <= SAFE;
      settle_cnt <= '0;
      wd <= '0;
      jointFreqCmd <= '0;
      setPoint <= '0;
      jointEnable <= '0;
      DOUT <= '0;
      frame_strobe <= 1'b0;
      fault <= 1'b0;
      frame_count <= '0;
      bad_count <= '0;
    end else begin
      ssel_s1 <= SPI_SSEL;
      ssel_s2 <= ssel_s1;
      ssel_d <= ssel_s2;
      fstate <= fnext;
      settle_cnt <= settle_next;
      lstate <= lnext;
      frame_strobe <= latch;
      wd <= (lstate == RUN && !latch && !expire) ? wd + 32'd1 : '0;
      fault <= latch ? 1'b0 : expire ? 1'b1 : fault;
      if (latch) begin
        jointFreqCmd <= jointFreqCmd_raw;
        setPoint <= setPoint_raw;
        jointEnable <= jointEnable_raw;
        DOUT <= dout_raw;
        frame_count <= frame_count + 16'd1;
      end else if (expire) begin
        jointFreqCmd <= '0;
        setPoint <= '0;
        jointEnable <= '0;
        DOUT <= '0;
      end
      if (reject && bad_count != 8'hFF) bad_count <= bad_count + 8'd1;
    end
  end
endmodule
